// File: rtl/except_pack_pkg.sv
// except_pack shared definitions: bundle layout,
// memory access size codes and the alignment rule.
package except_pack_pkg;

  localparam int EXCEPTINFO_WD = 16;

  localparam int EI_CP0_MSB = 15;
  localparam int EI_CP0_LSB = 11;
  localparam int EI_DS      = 10;
  localparam int EI_PCM     = 9;
  localparam int EI_ADES    = 8;
  localparam int EI_ADEL    = 7;
  localparam int EI_OV      = 6;
  localparam int EI_SYS     = 5;
  localparam int EI_BRK     = 4;
  localparam int EI_RI      = 3;
  localparam int EI_ERET    = 2;
  localparam int EI_MFC0    = 1;
  localparam int EI_MTC0    = 0;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

  // Byte accesses and unknown size codes never fault.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic m;
    m = 1'b0;
    case (size)
      MEM_SZ_HALF: m = addr_lo[0];
      MEM_SZ_WORD: m = |addr_lo;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/except_slot_enc.sv
// except_pack per-slot encoder: alignment checks,
// priority one-hot and bad address selection.
module except_slot_enc
  import except_pack_pkg::*;
(
  input  logic                     valid,
  input  logic [31:0]              pc,
  input  logic                     ov,
  input  logic                     sys,
  input  logic                     brk,
  input  logic                     ri,
  input  logic                     eret,
  input  logic                     mfc0,
  input  logic                     mtc0,
  input  logic [4:0]               cp0_addr,
  input  logic                     mem_re,
  input  logic                     mem_we,
  input  logic [1:0]               mem_size,
  input  logic [31:0]              mem_addr,
  output logic [EXCEPTINFO_WD-1:0] info,
  output logic [31:0]              bad_addr,
  output logic                     is_exc
);

  logic pcm;
  logic mis;
  logic adel;
  logic ades;

  assign pcm  = |pc[1:0];
  assign mis  = misaligned(mem_size, mem_addr[1:0]);
  assign adel = mem_re & mis;
  assign ades = mem_we & mis;

  // Pick the single winning exception; cp0 ops survive only without one.
  always_comb begin
    info     = '0;
    bad_addr = '0;
    is_exc   = 1'b0;
    if (valid) begin
      info[EI_CP0_MSB:EI_CP0_LSB] = cp0_addr;
      priority case (1'b1)
        pcm: begin
          info[EI_PCM] = 1'b1;
          bad_addr     = pc;
        end
        ri:  info[EI_RI]  = 1'b1;
        sys: info[EI_SYS] = 1'b1;
        brk: info[EI_BRK] = 1'b1;
        ov:  info[EI_OV]  = 1'b1;
        adel: begin
          info[EI_ADEL] = 1'b1;
          bad_addr      = mem_addr;
        end
        ades: begin
          info[EI_ADES] = 1'b1;
          bad_addr      = mem_addr;
        end
        default: begin
          info[EI_ERET] = eret;
          info[EI_MFC0] = mfc0;
          info[EI_MTC0] = mtc0;
        end
      endcase
      is_exc = |info[EI_PCM:EI_RI];
    end
  end

endmodule

// File: rtl/except_pack.sv
// except_pack: EX/MEM exception bundle register for
// both issue slots, with squash and delay-slot tracking.
module except_pack
  import except_pack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_i1,
  input  logic [31:0] pc_i1,
  input  logic        is_branch_i1,
  input  logic        ov_i1,
  input  logic        sys_i1,
  input  logic        brk_i1,
  input  logic        ri_i1,
  input  logic        eret_i1,
  input  logic        mfc0_i1,
  input  logic        mtc0_i1,
  input  logic [4:0]  cp0_addr_i1,
  input  logic        mem_re_i1,
  input  logic        mem_we_i1,
  input  logic [1:0]  mem_size_i1,
  input  logic [31:0] mem_addr_i1,
  input  logic [31:0] rt_rdata_i1,
  input  logic        valid_i2,
  input  logic [31:0] pc_i2,
  input  logic        is_branch_i2,
  input  logic        ov_i2,
  input  logic        sys_i2,
  input  logic        brk_i2,
  input  logic        ri_i2,
  input  logic        eret_i2,
  input  logic        mfc0_i2,
  input  logic        mtc0_i2,
  input  logic [4:0]  cp0_addr_i2,
  input  logic        mem_re_i2,
  input  logic        mem_we_i2,
  input  logic [1:0]  mem_size_i2,
  input  logic [31:0] mem_addr_i2,
  input  logic [31:0] rt_rdata_i2,
  output logic [15:0] exceptinfo_i1,
  output logic [31:0] current_pc_i1,
  output logic [31:0] rt_rdata_out_i1,
  output logic [31:0] bad_addr_i1,
  output logic        kill_i1,
  output logic [15:0] exceptinfo_i2,
  output logic [31:0] current_pc_i2,
  output logic [31:0] rt_rdata_out_i2,
  output logic [31:0] bad_addr_i2,
  output logic        kill_i2
);

  logic [EXCEPTINFO_WD-1:0] enc_info1;
  logic [EXCEPTINFO_WD-1:0] enc_info2;
  logic [31:0]              enc_bad1;
  logic [31:0]              enc_bad2;
  logic                     enc_exc1;
  logic                     enc_exc2;

  logic                     ds_pending;
  logic                     s1_hit;
  logic                     ds_nxt;
  logic [EXCEPTINFO_WD-1:0] info1_nxt;
  logic [EXCEPTINFO_WD-1:0] info2_nxt;
  logic [31:0]              bad1_nxt;
  logic [31:0]              bad2_nxt;
  logic [31:0]              pc1_nxt;
  logic [31:0]              pc2_nxt;
  logic [31:0]              rt1_nxt;
  logic [31:0]              rt2_nxt;
  logic                     kill1_nxt;
  logic                     kill2_nxt;

  except_slot_enc u_enc1 (
    .valid    (valid_i1),
    .pc       (pc_i1),
    .ov       (ov_i1),
    .sys      (sys_i1),
    .brk      (brk_i1),
    .ri       (ri_i1),
    .eret     (eret_i1),
    .mfc0     (mfc0_i1),
    .mtc0     (mtc0_i1),
    .cp0_addr (cp0_addr_i1),
    .mem_re   (mem_re_i1),
    .mem_we   (mem_we_i1),
    .mem_size (mem_size_i1),
    .mem_addr (mem_addr_i1),
    .info     (enc_info1),
    .bad_addr (enc_bad1),
    .is_exc   (enc_exc1)
  );

  except_slot_enc u_enc2 (
    .valid    (valid_i2),
    .pc       (pc_i2),
    .ov       (ov_i2),
    .sys      (sys_i2),
    .brk      (brk_i2),
    .ri       (ri_i2),
    .eret     (eret_i2),
    .mfc0     (mfc0_i2),
    .mtc0     (mtc0_i2),
    .cp0_addr (cp0_addr_i2),
    .mem_re   (mem_re_i2),
    .mem_we   (mem_we_i2),
    .mem_size (mem_size_i2),
    .mem_addr (mem_addr_i2),
    .info     (enc_info2),
    .bad_addr (enc_bad2),
    .is_exc   (enc_exc2)
  );

  // Slot 1 excepting or eret-ing is older, so it squashes slot 2.
  assign s1_hit = |enc_info1[EI_PCM:EI_ERET];

  // Assemble the next bundles, delay-slot bits and kills.
  always_comb begin
    info1_nxt = enc_info1;
    info2_nxt = enc_info2;
    bad1_nxt  = enc_bad1;
    bad2_nxt  = enc_bad2;
    pc1_nxt   = valid_i1 ? pc_i1 : 32'h0;
    pc2_nxt   = valid_i2 ? pc_i2 : 32'h0;
    rt1_nxt   = valid_i1 ? rt_rdata_i1 : 32'h0;
    rt2_nxt   = valid_i2 ? rt_rdata_i2 : 32'h0;
    kill1_nxt = valid_i1 & enc_exc1;
    kill2_nxt = valid_i2 & (enc_exc2 | s1_hit);
    ds_nxt    = ds_pending;
    if (valid_i1) begin
      info1_nxt[EI_DS] = ds_pending;
    end
    if (valid_i2) begin
      info2_nxt[EI_DS] = valid_i1 & is_branch_i1;
    end
    if (s1_hit) begin
      info2_nxt = '0;
      bad2_nxt  = '0;
    end
    if (valid_i1 | valid_i2) begin
      ds_nxt = valid_i2 ? is_branch_i2 : is_branch_i1;
    end
  end

  // Stage register: flush beats stall, stall holds, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exceptinfo_i1   <= '0;
      exceptinfo_i2   <= '0;
      current_pc_i1   <= '0;
      current_pc_i2   <= '0;
      rt_rdata_out_i1 <= '0;
      rt_rdata_out_i2 <= '0;
      bad_addr_i1     <= '0;
      bad_addr_i2     <= '0;
      kill_i1         <= 1'b0;
      kill_i2         <= 1'b0;
      ds_pending      <= 1'b0;
    end else if (flush) begin
      exceptinfo_i1   <= '0;
      exceptinfo_i2   <= '0;
      current_pc_i1   <= '0;
      current_pc_i2   <= '0;
      rt_rdata_out_i1 <= '0;
      rt_rdata_out_i2 <= '0;
      bad_addr_i1     <= '0;
      bad_addr_i2     <= '0;
      kill_i1         <= 1'b0;
      kill_i2         <= 1'b0;
      ds_pending      <= 1'b0;
    end else if (!stall) begin
      exceptinfo_i1   <= info1_nxt;
      exceptinfo_i2   <= info2_nxt;
      current_pc_i1   <= pc1_nxt;
      current_pc_i2   <= pc2_nxt;
      rt_rdata_out_i1 <= rt1_nxt;
      rt_rdata_out_i2 <= rt2_nxt;
      bad_addr_i1     <= bad1_nxt;
      bad_addr_i2     <= bad2_nxt;
      kill_i1         <= kill1_nxt;
      kill_i2         <= kill2_nxt;
      ds_pending      <= ds_nxt;
    end
  end

endmodule

// File: tb/tb_except_pack.sv
// except_pack bench: directed vectors with
// hand-computed bundles, kills and addresses.
module tb_except_pack;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_i1, valid_i2;
  logic [31:0] pc_i1, pc_i2;
  logic        is_branch_i1, is_branch_i2;
  logic        ov_i1, ov_i2;
  logic        sys_i1, sys_i2;
  logic        brk_i1, brk_i2;
  logic        ri_i1, ri_i2;
  logic        eret_i1, eret_i2;
  logic        mfc0_i1, mfc0_i2;
  logic        mtc0_i1, mtc0_i2;
  logic [4:0]  cp0_addr_i1, cp0_addr_i2;
  logic        mem_re_i1, mem_re_i2;
  logic        mem_we_i1, mem_we_i2;
  logic [1:0]  mem_size_i1, mem_size_i2;
  logic [31:0] mem_addr_i1, mem_addr_i2;
  logic [31:0] rt_rdata_i1, rt_rdata_i2;
  logic [15:0] exceptinfo_i1, exceptinfo_i2;
  logic [31:0] current_pc_i1, current_pc_i2;
  logic [31:0] rt_rdata_out_i1, rt_rdata_out_i2;
  logic [31:0] bad_addr_i1, bad_addr_i2;
  logic        kill_i1, kill_i2;

  int n_checks;
  int n_errors;

  except_pack dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .valid_i1        (valid_i1),
    .pc_i1           (pc_i1),
    .is_branch_i1    (is_branch_i1),
    .ov_i1           (ov_i1),
    .sys_i1          (sys_i1),
    .brk_i1          (brk_i1),
    .ri_i1           (ri_i1),
    .eret_i1         (eret_i1),
    .mfc0_i1         (mfc0_i1),
    .mtc0_i1         (mtc0_i1),
    .cp0_addr_i1     (cp0_addr_i1),
    .mem_re_i1       (mem_re_i1),
    .mem_we_i1       (mem_we_i1),
    .mem_size_i1     (mem_size_i1),
    .mem_addr_i1     (mem_addr_i1),
    .rt_rdata_i1     (rt_rdata_i1),
    .valid_i2        (valid_i2),
    .pc_i2           (pc_i2),
    .is_branch_i2    (is_branch_i2),
    .ov_i2           (ov_i2),
    .sys_i2          (sys_i2),
    .brk_i2          (brk_i2),
    .ri_i2           (ri_i2),
    .eret_i2         (eret_i2),
    .mfc0_i2         (mfc0_i2),
    .mtc0_i2         (mtc0_i2),
    .cp0_addr_i2     (cp0_addr_i2),
    .mem_re_i2       (mem_re_i2),
    .mem_we_i2       (mem_we_i2),
    .mem_size_i2     (mem_size_i2),
    .mem_addr_i2     (mem_addr_i2),
    .rt_rdata_i2     (rt_rdata_i2),
    .exceptinfo_i1   (exceptinfo_i1),
    .current_pc_i1   (current_pc_i1),
    .rt_rdata_out_i1 (rt_rdata_out_i1),
    .bad_addr_i1     (bad_addr_i1),
    .kill_i1         (kill_i1),
    .exceptinfo_i2   (exceptinfo_i2),
    .current_pc_i2   (current_pc_i2),
    .rt_rdata_out_i2 (rt_rdata_out_i2),
    .bad_addr_i2     (bad_addr_i2),
    .kill_i2         (kill_i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0;
    valid_i1 = 0; valid_i2 = 0;
    pc_i1 = 0; pc_i2 = 0;
    is_branch_i1 = 0; is_branch_i2 = 0;
    ov_i1 = 0; ov_i2 = 0;
    sys_i1 = 0; sys_i2 = 0;
    brk_i1 = 0; brk_i2 = 0;
    ri_i1 = 0; ri_i2 = 0;
    eret_i1 = 0; eret_i2 = 0;
    mfc0_i1 = 0; mfc0_i2 = 0;
    mtc0_i1 = 0; mtc0_i2 = 0;
    cp0_addr_i1 = 0; cp0_addr_i2 = 0;
    mem_re_i1 = 0; mem_re_i2 = 0;
    mem_we_i1 = 0; mem_we_i2 = 0;
    mem_size_i1 = 0; mem_size_i2 = 0;
    mem_addr_i1 = 0; mem_addr_i2 = 0;
    rt_rdata_i1 = 0; rt_rdata_i2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 0;
    idle();
    #12;
    check("rst_info1", 32'(exceptinfo_i1), 32'h0);
    check("rst_info2", 32'(exceptinfo_i2), 32'h0);
    check("rst_kill", 32'({kill_i1, kill_i2}), 32'h0);
    check("rst_pc1", current_pc_i1, 32'h0);
    rst_n = 1;

    // lw to 0x1002 in slot 1 squashes slot 2
    valid_i1 = 1; pc_i1 = 32'hBFC00100;
    mem_re_i1 = 1; mem_size_i1 = 2'b10;
    mem_addr_i1 = 32'h1002;
    valid_i2 = 1; pc_i2 = 32'hBFC00104;
    tick();
    check("lw_info1", 32'(exceptinfo_i1), 32'h0080);
    check("lw_bad1", bad_addr_i1, 32'h1002);
    check("lw_kill1", 32'(kill_i1), 32'h1);
    check("lw_pc1", current_pc_i1, 32'hBFC00100);
    check("lw_info2", 32'(exceptinfo_i2), 32'h0);
    check("lw_kill2", 32'(kill_i2), 32'h1);

    // misaligned PC beats RI
    idle();
    valid_i1 = 1; pc_i1 = 32'h00400002; ri_i1 = 1;
    tick();
    check("pcm_info1", 32'(exceptinfo_i1), 32'h0200);
    check("pcm_bad1", bad_addr_i1, 32'h00400002);
    check("pcm_pc2", current_pc_i2, 32'h0);
    check("pcm_kill2", 32'(kill_i2), 32'h0);

    // branch in slot 2, next slot 1 is in the delay slot
    idle();
    valid_i1 = 1; pc_i1 = 32'h100; rt_rdata_i1 = 32'hDEADBEEF;
    valid_i2 = 1; pc_i2 = 32'h104; is_branch_i2 = 1;
    tick();
    check("br2_info1", 32'(exceptinfo_i1), 32'h0);
    check("br2_info2", 32'(exceptinfo_i2), 32'h0);
    check("br2_rt1", rt_rdata_out_i1, 32'hDEADBEEF);
    idle();
    valid_i1 = 1; pc_i1 = 32'h108;
    tick();
    check("ds_info1", 32'(exceptinfo_i1), 32'h0400);

    // same, with a stall between branch and delay slot
    idle();
    valid_i1 = 1; pc_i1 = 32'h110;
    valid_i2 = 1; pc_i2 = 32'h114; is_branch_i2 = 1;
    tick();
    idle();
    stall = 1; valid_i1 = 1; pc_i1 = 32'h200; ri_i1 = 1;
    tick();
    check("stl_info1", 32'(exceptinfo_i1), 32'h0);
    check("stl_pc1", current_pc_i1, 32'h110);
    check("stl_pc2", current_pc_i2, 32'h114);
    idle();
    valid_i1 = 1; pc_i1 = 32'h300;
    tick();
    check("stl_ds1", 32'(exceptinfo_i1), 32'h0400);

    // branch in slot 1, misaligned sh in slot 2
    idle();
    valid_i1 = 1; pc_i1 = 32'h400; is_branch_i1 = 1;
    valid_i2 = 1; pc_i2 = 32'h404;
    mem_we_i2 = 1; mem_size_i2 = 2'b01; mem_addr_i2 = 32'h2001;
    tick();
    check("sh_info2", 32'(exceptinfo_i2), 32'h0500);
    check("sh_bad2", bad_addr_i2, 32'h2001);
    check("sh_kill2", 32'(kill_i2), 32'h1);
    check("sh_kill1", 32'(kill_i1), 32'h0);

    // flush with stall clears bundle and pending delay slot
    idle();
    valid_i1 = 1; pc_i1 = 32'h500; is_branch_i1 = 1; ov_i1 = 1;
    tick();
    check("ov_info1", 32'(exceptinfo_i1), 32'h0040);
    check("ov_kill1", 32'(kill_i1), 32'h1);
    flush = 1; stall = 1;
    tick();
    check("fl_info1", 32'(exceptinfo_i1), 32'h0);
    check("fl_kill1", 32'(kill_i1), 32'h0);
    check("fl_pc1", current_pc_i1, 32'h0);
    idle();
    valid_i1 = 1; pc_i1 = 32'h600;
    tick();
    check("fl_ds1", 32'(exceptinfo_i1), 32'h0);

    // overflow drops mtc0, keeps cp0 addr; slot 2 squashed
    idle();
    valid_i1 = 1; pc_i1 = 32'h700; ov_i1 = 1;
    mtc0_i1 = 1; cp0_addr_i1 = 5'd12;
    valid_i2 = 1; pc_i2 = 32'h704;
    mtc0_i2 = 1; cp0_addr_i2 = 5'd12;
    tick();
    check("mt_info1", 32'(exceptinfo_i1), 32'h6040);
    check("mt_info2", 32'(exceptinfo_i2), 32'h0);
    check("mt_kill2", 32'(kill_i2), 32'h1);

    // byte and aligned half never fault; RI beats overflow
    idle();
    valid_i1 = 1; pc_i1 = 32'h800;
    mem_re_i1 = 1; mem_size_i1 = 2'b00; mem_addr_i1 = 32'h1003;
    valid_i2 = 1; pc_i2 = 32'h804;
    mem_re_i2 = 1; mem_size_i2 = 2'b01; mem_addr_i2 = 32'h1002;
    tick();
    check("lb_info1", 32'(exceptinfo_i1), 32'h0);
    check("lh_info2", 32'(exceptinfo_i2), 32'h0);
    check("lh_kill2", 32'(kill_i2), 32'h0);
    idle();
    valid_i1 = 1; pc_i1 = 32'h900; ri_i1 = 1; ov_i1 = 1;
    tick();
    check("ri_info1", 32'(exceptinfo_i1), 32'h0008);
    check("ri_bad1", bad_addr_i1, 32'h0);

    // eret in slot 1 squashes syscall in slot 2
    idle();
    valid_i1 = 1; pc_i1 = 32'hA00; eret_i1 = 1;
    valid_i2 = 1; pc_i2 = 32'hA04; sys_i2 = 1;
    tick();
    check("er_info1", 32'(exceptinfo_i1), 32'h0004);
    check("er_info2", 32'(exceptinfo_i2), 32'h0);
    check("er_kill2", 32'(kill_i2), 32'h1);

    // asynchronous reset while stalled
    stall = 1;
    #2;
    rst_n = 0;
    #1;
    check("ar_info1", 32'(exceptinfo_i1), 32'h0);
    check("ar_kill2", 32'(kill_i2), 32'h0);
    check("ar_pc1", current_pc_i1, 32'h0);
    idle();
    rst_n = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
